// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types for the core memory bus arbiter
package mem_bus_arbiter_pkg;

   localparam int MEM_ADDR_W = 64;
   localparam int MEM_DATA_W = 64;
   localparam int MEM_STRB_W = MEM_DATA_W / 8;

   localparam logic [2:0] MSIZE_B = 3'd0;
   localparam logic [2:0] MSIZE_H = 3'd1;
   localparam logic [2:0] MSIZE_W = 3'd2;
   localparam logic [2:0] MSIZE_D = 3'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   // Sized for the widest bus; narrower instances use the low bits.
   typedef struct packed {
      logic [MEM_ADDR_W-1:0] addr;
      logic                  write;
      logic [2:0]            size;
      logic [MEM_STRB_W-1:0] strobe;
      logic [MEM_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// rtl/mem_bus_arbiter_rr_pick.sv - combinational round-robin picker with optional requester-0 priority
module mem_bus_arbiter_rr_pick #(
   parameter  int NUM_REQ = 3,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IW-1:0]      last_grant,
   input  logic               prio0_en,
   output logic [IW-1:0]      grant,
   output logic               any
);

   always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      any   = 1'b0;
      if (prio0_en && valid[0]) begin
         any = 1'b1;
      end else begin
         // Search starts one past the last winner and wraps.
         for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any && valid[IW'(idx)]) begin
               grant = IW'(idx);
               any   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares the core memory bus among PTW/dbus/ibus, one transaction at a time
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = 3,
   parameter  int ADDR_W  = 64,
   parameter  int DATA_W  = 64,
   parameter  bit PRIO0   = 1'b1,
   parameter  int TIMEOUT = 1024,
   localparam int IW      = $clog2(NUM_REQ),
   localparam int SW      = DATA_W / 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ-1:0]             req_write,
   input  logic [NUM_REQ-1:0][2:0]        req_size,
   input  logic [NUM_REQ-1:0][SW-1:0]     req_strobe,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]             resp_valid,
   output logic [DATA_W-1:0]              resp_rdata,
   output logic                           bus_valid,
   output logic [ADDR_W-1:0]              bus_addr,
   output logic                           bus_write,
   output logic [2:0]                     bus_size,
   output logic [SW-1:0]                  bus_strobe,
   output logic [DATA_W-1:0]              bus_wdata,
   input  logic                           bus_ready,
   input  logic                           bus_rvalid,
   input  logic [DATA_W-1:0]              bus_rdata,
   output logic [IW-1:0]                  owner,
   output logic                           busy,
   output logic                           timeout,
   output logic                           spurious
);

   localparam int          CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
   localparam logic [CW-1:0] TO_M1  = CW'(TIMEOUT - 1);

   arb_state_e       state;
   mem_req_t         lat;
   logic [IW-1:0]    last_grant;
   logic [CW-1:0]    wcnt;
   logic [IW-1:0]    pick;
   logic             pick_any;
   logic             done;

   mem_bus_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .valid      (req_valid),
      .last_grant (last_grant),
      .prio0_en   (PRIO0),
      .grant      (pick),
      .any        (pick_any)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         lat        <= '0;
         owner      <= '0;
         last_grant <= IW'(NUM_REQ - 1);
         wcnt       <= '0;
         timeout    <= 1'b0;
         spurious   <= 1'b0;
         bus_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus_rvalid) spurious <= 1'b1;
               if (pick_any) begin
                  lat.addr   <= MEM_ADDR_W'(req_addr[pick]);
                  lat.write  <= req_write[pick];
                  lat.size   <= req_size[pick];
                  lat.strobe <= req_write[pick] ? MEM_STRB_W'(req_strobe[pick]) : '0;
                  lat.wdata  <= MEM_DATA_W'(req_wdata[pick]);
                  owner      <= pick;
                  last_grant <= pick;
                  bus_valid  <= 1'b1;
                  busy       <= 1'b1;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (bus_ready) begin
                  bus_valid <= 1'b0;
                  if (bus_rvalid) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     state <= RESP;
                  end
               end else if (bus_rvalid) begin
                  spurious <= 1'b1;
               end
            end
            RESP: begin
               if (bus_rvalid) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Watchdog only observes; a hung transaction keeps its state.
         if (state == IDLE) begin
            wcnt <= '0;
         end else if (wcnt != TO_MAX) begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == TO_M1) timeout <= 1'b1;
         end
      end
   end

   assign done = ((state == REQ) && bus_ready && bus_rvalid) ||
                 ((state == RESP) && bus_rvalid);

   always_comb begin
      resp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         resp_valid[i] = done && (owner == IW'(i));
      end
   end

   assign resp_rdata = done ? bus_rdata : '0;
   assign bus_addr   = lat.addr[ADDR_W-1:0];
   assign bus_write  = lat.write;
   assign bus_size   = lat.size;
   assign bus_strobe = lat.strobe[SW-1:0];
   assign bus_wdata  = lat.wdata[DATA_W-1:0];

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single core-side memory bus among NUM_REQ requesters (index 0 page-table walker, 1 dbus, 2 ibus), one outstanding transaction at a time.
- Sits between the core's ibus/dbus/PTW ports and the cache/uncore port.
- Arbitration is round-robin with an optional fixed-priority override for requester 0.
- A watchdog flags downstream hangs.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 64, address width.
- DATA_W, 64, data width; strobe width DATA_W/8.
- PRIO0, 1, 1 = requester 0 wins whenever valid; 0 = pure round-robin.
- TIMEOUT, 1024, cycles in a transaction before timeout flag sets.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held high with stable fields until that requester's resp_valid.
- req_addr  in  NUM_REQ x ADDR_W  request address.
- req_write  in  NUM_REQ  1 = store.
- req_size  in  NUM_REQ x 3  log2 bytes (0..3).
- req_strobe  in  NUM_REQ x DATA_W/8  byte enables (store only).
- req_wdata  in  NUM_REQ x DATA_W  store data.
- resp_valid  out  NUM_REQ  one-cycle completion pulse to the owner.
- resp_rdata  out  DATA_W  load data, valid with resp_valid.
- bus_valid  out  1  downstream request.
- bus_addr / bus_write / bus_size / bus_strobe / bus_wdata  out  ADDR_W/1/3/DATA_W/8/DATA_W  latched request fields.
- bus_ready  in  1  downstream accepted request.
- bus_rvalid  in  1  downstream completion.
- bus_rdata  in  DATA_W  downstream load data.
- owner  out  clog2(NUM_REQ)  current grant index.
- busy  out  1  state != IDLE.
- timeout  out  1  sticky watchdog flag.
- spurious  out  1  sticky: bus_rvalid seen in IDLE or before acceptance.

Behaviour:
- Reset values: state IDLE, all outputs 0, last_grant = NUM_REQ-1, wait counter 0, both sticky flags 0. Reset mid-transaction abandons it; no resp_valid is issued.
- States: IDLE, REQ, RESP.
- IDLE, any req_valid:
  - Winner: if PRIO0 and req_valid[0], winner = 0. Otherwise the first valid index searching last_grant+1 upward with wrap modulo NUM_REQ.
  - Latch the winner's fields into bus_* registers; owner = winner; last_grant = winner.
  - Next state REQ.
- REQ:
  - bus_valid=1; fields stable.
  - bus_ready=0: stay in REQ.
  - bus_ready=1 and bus_rvalid=0: go to RESP.
  - bus_ready=1 and bus_rvalid=1 in the same cycle: complete immediately and go to IDLE.
  - bus_rvalid=1 with bus_ready=0: set spurious and ignore.
- RESP:
  - bus_valid=0.
  - bus_rvalid=1: resp_valid[owner]=1 and resp_rdata=bus_rdata, both combinational in the same cycle; next state IDLE.
- Outside completion: resp_valid=0 and resp_rdata=0.
- Latency: request seen in cycle t gives bus_valid at t+1. Minimum turnaround is 2 cycles (t+1 ready+rvalid, resp at t+1). The next arbitration happens in the IDLE cycle after completion.
- A requester may keep req_valid high after its resp_valid to issue a back-to-back request. That request goes through round-robin, so with contention another requester wins first.
- If a requester drops req_valid while granted, the transaction still completes and resp_valid still pulses. There is no abort.
- Watchdog:
  - Counter cleared in IDLE, increments each cycle in REQ or RESP, saturates.
  - When the count reaches TIMEOUT, timeout is set (sticky until reset). State is not changed.
- bus_rvalid in IDLE: set spurious and ignore.
- bus_strobe is forced to 0 when bus_write=0.
- Stores complete on bus_rvalid like loads; resp_rdata is don't-care to the requester, but the arbiter passes bus_rdata through unchanged.

Decomposition:
- Shared package (common): arb_state_e {IDLE, REQ, RESP}; mem_req_t struct {addr, write, size, strobe, wdata}; MSIZE_* constants.
- One sub-module: rr_pick (combinational round-robin picker; inputs valid vector, last_grant, prio0_en; outputs grant index and any). All sequencing stays in mem_bus_arbiter.

Test Plan:
- Single load: req_valid=3'b100, addr 0x8000_0010; bus_ready=1 at t+1, bus_rvalid at t+3 with 0xDEAD → bus_valid at t+1 only, resp_valid=3'b100 at t+3 with rdata 0xDEAD, busy falls at t+4.
- Contention, PRIO0=0: all three valid continuously, each completing 1 cycle after acceptance → grant order 0,1,2,0,1,2; each requester gets exactly one resp per 3 transactions.
- PRIO0=1: req 0 and 2 both held valid → requester 0 wins every arbitration; requester 2 is granted only in an arbitration cycle where req_valid[0]=0.
- Same-cycle ready+rvalid on a store, addr 0x100, strobe 0x0F → resp at t+1, next grant evaluated at t+2; with load bus_write=0, bus_strobe=0.
- Watchdog: TIMEOUT=8, bus_ready held 0 → timeout=1 exactly when the counter reaches 8, stays 1 after later completion; bus_rvalid pulse in IDLE → spurious=1.
- Async reset asserted while in RESP → all outputs 0 immediately, no resp_valid; after release, pending req_valid[1] granted first (last_grant reset to NUM_REQ-1 → search starts at 0; req_valid[0]=0).
